expand_seq_ctrl: RTL

EXPAND_SEQ_CTRL -- requirements
Module: expand_seq_ctrl

---
 rtl/expand_seq_ctrl_pkg.sv | 17 +
 rtl/expand_seq_ctrl_expand.sv | 29 ++
 rtl/expand_seq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/expand_seq_ctrl_pkg.sv
// Shared TPU package for the image expansion sequencer.
// Holds the default geometry (32x32 packed binary image, 8 chunks of
// 128 byte lanes) and the controller state encoding.
package expand_seq_ctrl_pkg;

    localparam int IMG_BITS    = 1024;
    localparam int NUM_CHUNKS  = 8;
    localparam int CHUNK_BYTES = 128;
    localparam int IDX_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/expand_seq_ctrl_expand.sv
// expand_to_8bit: expands one chunk of a packed 1-bit image into 8-bit lanes.
// Chunk <addr> covers image bits [addr*CHUNK_BYTES +: CHUNK_BYTES]; image bit i
// of that window becomes byte lane i, 8'hFF for a set pixel, 8'h00 otherwise.
//   data_in  : packed image (DATA_BITS)
//   addr     : chunk index (ADDR_W)
//   data_out : expanded chunk (CHUNK_BYTES*8), purely combinational
module expand_to_8bit #(
    parameter int DATA_BITS   = 1024,
    parameter int CHUNK_BYTES = 128,
    parameter int ADDR_W      = 3
) (
    input  logic [DATA_BITS-1:0]     data_in,
    input  logic [ADDR_W-1:0]        addr,
    output logic [CHUNK_BYTES*8-1:0] data_out
);

    localparam int BASE_W = $clog2(DATA_BITS);

    logic [BASE_W-1:0]      w_base;
    logic [CHUNK_BYTES-1:0] w_slice;

    assign w_base  = BASE_W'(addr) * BASE_W'(CHUNK_BYTES);
    assign w_slice = data_in[w_base +: CHUNK_BYTES];

    for (genvar i = 0; i < CHUNK_BYTES; i++) begin : g_lane
        assign data_out[i*8 +: 8] = {8{w_slice[i]}};
    end

endmodule

// File: rtl/expand_seq_ctrl.sv
// expand_seq_ctrl: latches a packed binary image on start and streams its
// expanded chunks to a consumer with a valid/ready handshake, then pulses done.
//   clk, rst     : clock, async active-high reset
//   img_in,start : image and job request (image sampled only on accepted start)
//   abort        : cancels a running job, wins over start and transfers
//   busy         : job in progress (STREAM or DONE)
//   chunk_*      : expanded chunk, qualifier, index, consumer ready
//   last, done   : final-chunk marker, one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | presenting chunk r_idx, advancing on each accepted transfer
// DONE   | one-cycle completion pulse, then back to IDLE
module expand_seq_ctrl #(
    parameter int IMG_BITS    = expand_seq_ctrl_pkg::IMG_BITS,
    parameter int NUM_CHUNKS  = expand_seq_ctrl_pkg::NUM_CHUNKS,
    parameter int CHUNK_BYTES = expand_seq_ctrl_pkg::CHUNK_BYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IMG_BITS-1:0]      img_in,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic [CHUNK_BYTES*8-1:0] chunk_data,
    output logic                     chunk_valid,
    input  logic                     chunk_ready,
    output logic [2:0]               chunk_idx,
    output logic                     last,
    output logic                     done
);

    import expand_seq_ctrl_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t               r_state;
    logic [IMG_BITS-1:0]  r_image;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_image <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_image <= img_in;
                        r_idx   <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_last  <= (NUM_CHUNKS == 1);
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (chunk_ready) begin
                        if (r_idx == LAST_IDX) begin
                            // index parks at the final chunk; no wrap
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx  <= r_idx + IDX_W'(1);
                            r_last <= ((r_idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    expand_to_8bit #(
        .DATA_BITS   (IMG_BITS),
        .CHUNK_BYTES (CHUNK_BYTES),
        .ADDR_W      (IDX_W)
    ) u_expand (
        .data_in  (r_image),
        .addr     (r_idx),
        .data_out (chunk_data)
    );

    assign busy        = r_busy;
    assign chunk_valid = r_valid;
    assign chunk_idx   = r_idx;
    assign last        = r_last;
    assign done        = r_done;

endmodule
